id_ex_stage_reg: RTL and testbench
==================================

// Module: id_ex_stage_reg
// PURPOSE
//  ID/EX pipeline register for the 16-bit core. Captures decoded operands and control from ID
//  and presents the registered *_EX fields consumed by the EX-stage operand muxes and ALU.
//  Detects load-use hazards and inserts one bubble. Honours the downstream hold (stall_ext)
//  and the branch flush (flush_EX). A flush that arrives while the stage is held is deferred.
// PARAMETERS
//  DW    16  datapath width (PC, register data, immediate)
//  RW    3   register-address width
//  AOPW  4   ALU opcode width
//  CNTW  16  bubble-counter width
// PORTS
//  clk           in   1     single clock; all state updates on rising edge
//  rst_n         in   1     synchronous, active-low reset
//  valid_ID      in   1     ID slot holds a real instruction
//  PC_ID         in   DW    PC of the ID instruction
//  Rout1_ID      in   DW    register-file read data, port 1
//  Rout2_ID      in   DW    register-file read data, port 2
//  Imm_ID        in   DW    sign-extended immediate
//  Rs1_ID        in   RW    source register 1
//  Rs2_ID        in   RW    source register 2
//  Rd_ID         in   RW    destination register
//  Op1_Sel_ID    in   2     00 zero, 01 Rout1, 10 PC, 11 reserved (treated as zero)
//  Op2_Sel_ID    in   2     00 zero, 01 Rout2, 10 Imm, 11 reserved (treated as zero)
//  ALU_Op_ID     in   AOPW  ALU operation
//  RegWrite_ID   in   1     instruction writes Rd
//  MemRead_ID    in   1     instruction is a load
//  MemWrite_ID   in   1     instruction is a store
//  stall_ext     in   1     EX cannot advance; hold every EX register
//  flush_EX      in   1     branch taken; the ID instruction is wrong-path and must not enter EX
//  *_EX          out  =     registered copy of every *_ID field above (PC..MemWrite)
//  valid_EX      out  1     EX slot holds a real instruction
//  stall_ID      out  1     freeze PC and IF/ID = stall_ext | load_use
//  bubble_cnt    out  CNTW  saturating count of bubbles inserted (load-use plus flush)
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): all *_EX, valid_EX, pend_flush and bubble_cnt go to 0.
//    stall_ID is combinational and reads 0 after reset.
//  - load_use (combinational) is asserted when all of the following hold:
//      valid_ID, valid_EX, MemRead_EX, RegWrite_EX, and
//      ((Op1_Sel_ID==01 && Rs1_ID==Rd_EX) || (Op2_Sel_ID==01 && Rs2_ID==Rd_EX)).
//  - Bubble: valid_EX, RegWrite_EX, MemRead_EX and MemWrite_EX = 0. Op1/Op2_Sel_EX = 00.
//    All data, register-address and ALU_Op fields = 0.
//  - Edge priority, highest first:
//     1 reset.
//     2 stall_ext: hold all EX registers. If flush_EX is also 1, set pend_flush.
//     3 flush_EX | pend_flush: load a bubble, clear pend_flush, bubble_cnt += 1.
//     4 load_use: load a bubble, bubble_cnt += 1. ID is held via stall_ID.
//     5 otherwise: load the ID fields. valid_EX = valid_ID.
//  - Latency is 1 cycle ID->EX. A load-use hazard costs exactly 1 bubble; the next cycle
//    load_use deasserts because valid_EX=0.
//  - flush_EX and load_use in the same cycle: flush wins; one bubble, counted once.
//  - bubble_cnt saturates at all-ones and does not wrap.
//  - A reset that arrives mid-hold or with pend_flush set clears everything; no deferred flush survives.
//  - valid_ID=0 with no other event: loads a bubble-equivalent slot but does not increment bubble_cnt.
// STRUCTURE
//  - Package id_ex_pkg holds:
//      OP1_SEL_ZERO/REG/PC and OP2_SEL_ZERO/REG/IMM localparams.
//      A packed ctrl bundle: Op1_Sel, Op2_Sel, ALU_Op, RegWrite, MemRead, MemWrite, Rd.
//      BUBBLE_CTRL constant.
//  - One sub-module, load_use_detect: purely combinational, takes the ID sources and selects
//    plus the EX Rd/MemRead/RegWrite/valid, and outputs load_use.
// TESTING
//  - Reset: rst_n=0 for 2 cycles with random inputs -> all outputs 0, stall_ID=0.
//  - Pass-through: valid_ID=1, PC_ID=16'h0040, Op1_Sel_ID=10, ALU_Op_ID=4'h2
//      -> next cycle PC_EX=16'h0040, Op1_Sel_EX=10, valid_EX=1.
//  - Load-use, hit:
//      LD R3 (MemRead, RegWrite, Rd=3) in EX; ID has Rs1=3, Op1_Sel=01
//      -> stall_ID=1 for 1 cycle, one bubble, bubble_cnt=1, then the dependent instruction enters EX.
//  - Load-use, no hit: same as above but Op1_Sel_ID=10 (PC) -> no stall, no bubble.
//  - Deferred flush: stall_ext=1 and flush_EX=1 at cycle N, stall_ext=1 at N+1, released at N+2
//      -> EX held at N and N+1; bubble at N+2; bubble_cnt +1.
//  - Saturation: preload 65534 bubbles, then force 3 flushes -> bubble_cnt=16'hFFFF and holds.

Source files
------------

// File: rtl/id_ex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pkg
// Description : Operand-select encodings and the EX control bundle for the
//               ID/EX stage register.
// Revision    : 1.0
// ============================================================================
package id_ex_pkg;

    localparam int ID_EX_RW   = 3;
    localparam int ID_EX_AOPW = 4;

    localparam logic [1:0] OP1_SEL_ZERO = 2'b00;
    localparam logic [1:0] OP1_SEL_REG  = 2'b01;
    localparam logic [1:0] OP1_SEL_PC   = 2'b10;

    localparam logic [1:0] OP2_SEL_ZERO = 2'b00;
    localparam logic [1:0] OP2_SEL_REG  = 2'b01;
    localparam logic [1:0] OP2_SEL_IMM  = 2'b10;

    typedef struct packed {
        logic [1:0]            Op1_Sel;
        logic [1:0]            Op2_Sel;
        logic [ID_EX_AOPW-1:0] ALU_Op;
        logic                  RegWrite;
        logic                  MemRead;
        logic                  MemWrite;
        logic [ID_EX_RW-1:0]   Rd;
    } ctrl_t;

    // All-zero control: no write, no memory access, both operands select zero.
    localparam ctrl_t BUBBLE_CTRL = '0;

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_reg_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Flags an ID instruction that reads the register a load in EX
//               is about to write.
// Revision    : 1.0
// ============================================================================
module load_use_detect
    import id_ex_pkg::*;
#(
    parameter int RW = 3
) (
    input  logic          i_valid_id,
    input  logic [RW-1:0] i_rs1_id,
    input  logic [RW-1:0] i_rs2_id,
    input  logic [1:0]    i_op1_sel_id,
    input  logic [1:0]    i_op2_sel_id,
    input  logic          i_valid_ex,
    input  logic [RW-1:0] i_rd_ex,
    input  logic          i_mem_read_ex,
    input  logic          i_reg_write_ex,
    output logic          o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    // Only a register-sourced operand can depend on the load result.
    assign w_rs1_hit  = (i_op1_sel_id == OP1_SEL_REG) && (i_rs1_id == i_rd_ex);
    assign w_rs2_hit  = (i_op2_sel_id == OP2_SEL_REG) && (i_rs2_id == i_rd_ex);

    assign o_load_use = i_valid_id && i_valid_ex && i_mem_read_ex && i_reg_write_ex
                        && (w_rs1_hit || w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_reg
// Description : ID/EX pipeline register with load-use bubble insertion,
//               downstream hold and deferred branch flush.
// Revision    : 1.0
// ============================================================================
module id_ex_stage_reg
    import id_ex_pkg::*;
#(
    parameter int DW   = 16,
    parameter int RW   = ID_EX_RW,
    parameter int AOPW = ID_EX_AOPW,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_ID,
    input  logic [DW-1:0]   PC_ID,
    input  logic [DW-1:0]   Rout1_ID,
    input  logic [DW-1:0]   Rout2_ID,
    input  logic [DW-1:0]   Imm_ID,
    input  logic [RW-1:0]   Rs1_ID,
    input  logic [RW-1:0]   Rs2_ID,
    input  logic [RW-1:0]   Rd_ID,
    input  logic [1:0]      Op1_Sel_ID,
    input  logic [1:0]      Op2_Sel_ID,
    input  logic [AOPW-1:0] ALU_Op_ID,
    input  logic            RegWrite_ID,
    input  logic            MemRead_ID,
    input  logic            MemWrite_ID,
    input  logic            stall_ext,
    input  logic            flush_EX,
    output logic [DW-1:0]   PC_EX,
    output logic [DW-1:0]   Rout1_EX,
    output logic [DW-1:0]   Rout2_EX,
    output logic [DW-1:0]   Imm_EX,
    output logic [RW-1:0]   Rs1_EX,
    output logic [RW-1:0]   Rs2_EX,
    output logic [RW-1:0]   Rd_EX,
    output logic [1:0]      Op1_Sel_EX,
    output logic [1:0]      Op2_Sel_EX,
    output logic [AOPW-1:0] ALU_Op_EX,
    output logic            RegWrite_EX,
    output logic            MemRead_EX,
    output logic            MemWrite_EX,
    output logic            valid_EX,
    output logic            stall_ID,
    output logic [CNTW-1:0] bubble_cnt
);

    logic            r_valid;
    logic [DW-1:0]   r_pc;
    logic [DW-1:0]   r_rout1;
    logic [DW-1:0]   r_rout2;
    logic [DW-1:0]   r_imm;
    logic [RW-1:0]   r_rs1;
    logic [RW-1:0]   r_rs2;
    ctrl_t           r_ctrl;
    logic            r_pend_flush;
    logic [CNTW-1:0] r_bubble_cnt;

    ctrl_t           w_ctrl_id;
    logic            w_load_use;
    logic            w_bubble;
    logic [CNTW-1:0] w_cnt_next;

    assign w_ctrl_id = '{Op1_Sel:  Op1_Sel_ID,
                         Op2_Sel:  Op2_Sel_ID,
                         ALU_Op:   ALU_Op_ID,
                         RegWrite: RegWrite_ID,
                         MemRead:  MemRead_ID,
                         MemWrite: MemWrite_ID,
                         Rd:       Rd_ID};

    load_use_detect #(
        .RW (RW)
    ) u_load_use_detect (
        .i_valid_id     (valid_ID),
        .i_rs1_id       (Rs1_ID),
        .i_rs2_id       (Rs2_ID),
        .i_op1_sel_id   (Op1_Sel_ID),
        .i_op2_sel_id   (Op2_Sel_ID),
        .i_valid_ex     (r_valid),
        .i_rd_ex        (r_ctrl.Rd),
        .i_mem_read_ex  (r_ctrl.MemRead),
        .i_reg_write_ex (r_ctrl.RegWrite),
        .o_load_use     (w_load_use)
    );

    // Flush outranks load-use, but both insert exactly one counted bubble.
    assign w_bubble   = flush_EX | r_pend_flush | w_load_use;
    assign w_cnt_next = (r_bubble_cnt == {CNTW{1'b1}}) ? r_bubble_cnt
                                                       : r_bubble_cnt + CNTW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_rout1      <= '0;
            r_rout2      <= '0;
            r_imm        <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_ctrl       <= BUBBLE_CTRL;
            r_pend_flush <= 1'b0;
            r_bubble_cnt <= '0;
        end else if (stall_ext) begin
            if (flush_EX) begin
                r_pend_flush <= 1'b1;
            end
        end else begin
            r_pend_flush <= 1'b0;
            if (w_bubble) begin
                r_bubble_cnt <= w_cnt_next;
            end
            // An empty ID slot is loaded as an uncounted bubble.
            if (w_bubble || !valid_ID) begin
                r_valid <= 1'b0;
                r_pc    <= '0;
                r_rout1 <= '0;
                r_rout2 <= '0;
                r_imm   <= '0;
                r_rs1   <= '0;
                r_rs2   <= '0;
                r_ctrl  <= BUBBLE_CTRL;
            end else begin
                r_valid <= 1'b1;
                r_pc    <= PC_ID;
                r_rout1 <= Rout1_ID;
                r_rout2 <= Rout2_ID;
                r_imm   <= Imm_ID;
                r_rs1   <= Rs1_ID;
                r_rs2   <= Rs2_ID;
                r_ctrl  <= w_ctrl_id;
            end
        end
    end

    assign stall_ID    = stall_ext | w_load_use;
    assign valid_EX    = r_valid;
    assign PC_EX       = r_pc;
    assign Rout1_EX    = r_rout1;
    assign Rout2_EX    = r_rout2;
    assign Imm_EX      = r_imm;
    assign Rs1_EX      = r_rs1;
    assign Rs2_EX      = r_rs2;
    assign Rd_EX       = r_ctrl.Rd;
    assign Op1_Sel_EX  = r_ctrl.Op1_Sel;
    assign Op2_Sel_EX  = r_ctrl.Op2_Sel;
    assign ALU_Op_EX   = r_ctrl.ALU_Op;
    assign RegWrite_EX = r_ctrl.RegWrite;
    assign MemRead_EX  = r_ctrl.MemRead;
    assign MemWrite_EX = r_ctrl.MemWrite;
    assign bubble_cnt  = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
`default_nettype none
// Testbench for id_ex_stage_reg: directed table, hand sequences and random
// stimulus checked against a behavioural model of the stage.
module tb_id_ex_stage_reg;

    typedef struct {
        logic        valid;
        logic [15:0] pc, r1, r2, imm;
        logic [2:0]  rs1, rs2, rd;
        logic [1:0]  s1, s2;
        logic [3:0]  op;
        logic        rw, mr, mw, stall, flush;
    } in_t;

    typedef struct {
        in_t         in;
        logic        e_stall;
        logic        e_valid;
        logic [15:0] e_pc;
        logic [15:0] e_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_ID;
    logic [15:0] PC_ID, Rout1_ID, Rout2_ID, Imm_ID;
    logic [2:0]  Rs1_ID, Rs2_ID, Rd_ID;
    logic [1:0]  Op1_Sel_ID, Op2_Sel_ID;
    logic [3:0]  ALU_Op_ID;
    logic        RegWrite_ID, MemRead_ID, MemWrite_ID, stall_ext, flush_EX;
    logic [15:0] PC_EX, Rout1_EX, Rout2_EX, Imm_EX;
    logic [2:0]  Rs1_EX, Rs2_EX, Rd_EX;
    logic [1:0]  Op1_Sel_EX, Op2_Sel_EX;
    logic [3:0]  ALU_Op_EX;
    logic        RegWrite_EX, MemRead_EX, MemWrite_EX, valid_EX, stall_ID;
    logic [15:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    in_t         ZERO;
    in_t         m_ex;
    logic        m_pend;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.DW(16), .RW(3), .AOPW(4), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .valid_ID(valid_ID), .PC_ID(PC_ID),
        .Rout1_ID(Rout1_ID), .Rout2_ID(Rout2_ID), .Imm_ID(Imm_ID),
        .Rs1_ID(Rs1_ID), .Rs2_ID(Rs2_ID), .Rd_ID(Rd_ID),
        .Op1_Sel_ID(Op1_Sel_ID), .Op2_Sel_ID(Op2_Sel_ID), .ALU_Op_ID(ALU_Op_ID),
        .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID), .MemWrite_ID(MemWrite_ID),
        .stall_ext(stall_ext), .flush_EX(flush_EX),
        .PC_EX(PC_EX), .Rout1_EX(Rout1_EX), .Rout2_EX(Rout2_EX), .Imm_EX(Imm_EX),
        .Rs1_EX(Rs1_EX), .Rs2_EX(Rs2_EX), .Rd_EX(Rd_EX),
        .Op1_Sel_EX(Op1_Sel_EX), .Op2_Sel_EX(Op2_Sel_EX), .ALU_Op_EX(ALU_Op_EX),
        .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
        .valid_EX(valid_EX), .stall_ID(stall_ID), .bubble_cnt(bubble_cnt)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic in_t mk(input logic v, input logic [15:0] pc,
                               input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd,
                               input logic [1:0] s1, input logic [1:0] s2, input logic [3:0] op,
                               input logic rw, input logic mr, input logic mw,
                               input logic st, input logic fl);
        in_t x;
        x.valid = v;  x.pc = pc;
        x.r1 = pc ^ 16'h1111; x.r2 = pc ^ 16'h2222; x.imm = pc ^ 16'h3333;
        x.rs1 = rs1; x.rs2 = rs2; x.rd = rd; x.s1 = s1; x.s2 = s2; x.op = op;
        x.rw = rw; x.mr = mr; x.mw = mw; x.stall = st; x.flush = fl;
        return x;
    endfunction

    function automatic in_t rnd();
        in_t x;
        x.valid = ($urandom_range(0, 5) != 0);
        x.pc = 16'($urandom); x.r1 = 16'($urandom); x.r2 = 16'($urandom); x.imm = 16'($urandom);
        x.rs1 = 3'($urandom); x.rs2 = 3'($urandom); x.rd = 3'($urandom);
        x.s1 = 2'($urandom); x.s2 = 2'($urandom); x.op = 4'($urandom);
        x.rw = 1'($urandom); x.mr = 1'($urandom); x.mw = 1'($urandom);
        x.stall = ($urandom_range(0, 4) == 0);
        x.flush = ($urandom_range(0, 7) == 0);
        return x;
    endfunction

    task automatic drive(input in_t x);
        valid_ID = x.valid; PC_ID = x.pc; Rout1_ID = x.r1; Rout2_ID = x.r2; Imm_ID = x.imm;
        Rs1_ID = x.rs1; Rs2_ID = x.rs2; Rd_ID = x.rd; Op1_Sel_ID = x.s1; Op2_Sel_ID = x.s2;
        ALU_Op_ID = x.op; RegWrite_ID = x.rw; MemRead_ID = x.mr; MemWrite_ID = x.mw;
        stall_ext = x.stall; flush_EX = x.flush;
    endtask

    // Does the ID instruction read the register a load in EX is producing?
    function automatic logic model_hazard(input in_t x);
        logic reads1, reads2;
        reads1 = (x.s1 == 2'b01) && (x.rs1 == m_ex.rd);
        reads2 = (x.s2 == 2'b01) && (x.rs2 == m_ex.rd);
        return x.valid && m_ex.valid && m_ex.mr && m_ex.rw && (reads1 || reads2);
    endfunction

    task automatic model_edge(input in_t x, input logic r);
        logic haz;
        haz = model_hazard(x);
        if (!r) begin
            m_ex = ZERO; m_pend = 1'b0; m_cnt = 16'd0;
        end else if (x.stall) begin
            if (x.flush) m_pend = 1'b1;
        end else begin
            if (x.flush || m_pend || haz) begin
                m_ex = ZERO;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end else begin
                m_ex = x.valid ? x : ZERO;
            end
            m_pend = 1'b0;
        end
    endtask

    task automatic check_outputs();
        logic [84:0] act, exp;
        act = {valid_EX, PC_EX, Rout1_EX, Rout2_EX, Imm_EX, Rs1_EX, Rs2_EX, Rd_EX,
               Op1_Sel_EX, Op2_Sel_EX, ALU_Op_EX, RegWrite_EX, MemRead_EX, MemWrite_EX};
        exp = {m_ex.valid, m_ex.pc, m_ex.r1, m_ex.r2, m_ex.imm, m_ex.rs1, m_ex.rs2, m_ex.rd,
               m_ex.s1, m_ex.s2, m_ex.op, m_ex.rw, m_ex.mr, m_ex.mw};
        chk("ex_fields", 128'(act), 128'(exp));
        chk("bubble_cnt", 128'(bubble_cnt), 128'(m_cnt));
    endtask

    // One clock: drive at negedge, check stall_ID before the edge, outputs after it.
    task automatic step(input in_t x, input logic r, output logic st);
        logic exp_st;
        @(negedge clk);
        rst_n = r;
        drive(x);
        #1;
        st = stall_ID;
        exp_st = x.stall | model_hazard(x);
        chk("stall_ID", 128'(st), 128'(exp_st));
        @(posedge clk);
        model_edge(x, r);
        #1;
        check_outputs();
    endtask

    vec_t tbl[10];

    initial begin : main
        logic st;
        ZERO = '{default: '0};
        m_ex = ZERO; m_pend = 1'b0; m_cnt = 16'd0;
        rst_n = 1'b0;
        drive(ZERO);

        // Reset held for two cycles under random inputs.
        for (int i = 0; i < 2; i++) step(rnd(), 1'b0, st);
        chk("reset_ex", 128'({valid_EX, PC_EX, Rout1_EX, Rout2_EX, Imm_EX, Rd_EX, Op1_Sel_EX,
                              ALU_Op_EX, RegWrite_EX, MemRead_EX, MemWrite_EX}), 128'd0);
        chk("reset_cnt", 128'(bubble_cnt), 128'd0);
        step(ZERO, 1'b1, st);
        chk("reset_stall_ID", 128'(st), 128'd0);

        //                   v  pc       rs1  rs2  rd   s1     s2     op    rw mr mw st fl
        tbl[0] = '{mk(1, 16'h0010, 3'd1, 3'd0, 3'd3, 2'b01, 2'b10, 4'h0, 1, 1, 0, 0, 0), 0, 1, 16'h0010, 16'd0};
        tbl[1] = '{mk(1, 16'h0012, 3'd3, 3'd0, 3'd4, 2'b01, 2'b00, 4'h1, 1, 0, 0, 0, 0), 1, 0, 16'h0000, 16'd1};
        tbl[2] = '{mk(1, 16'h0012, 3'd3, 3'd0, 3'd4, 2'b01, 2'b00, 4'h1, 1, 0, 0, 0, 0), 0, 1, 16'h0012, 16'd1};
        tbl[3] = '{mk(1, 16'h0040, 3'd0, 3'd0, 3'd1, 2'b10, 2'b00, 4'h2, 1, 0, 0, 0, 0), 0, 1, 16'h0040, 16'd1};
        tbl[4] = '{mk(1, 16'h0042, 3'd0, 3'd0, 3'd5, 2'b10, 2'b10, 4'h0, 1, 1, 0, 0, 0), 0, 1, 16'h0042, 16'd1};
        tbl[5] = '{mk(1, 16'h0044, 3'd5, 3'd1, 3'd6, 2'b10, 2'b00, 4'h3, 1, 0, 0, 0, 0), 0, 1, 16'h0044, 16'd1};
        tbl[6] = '{mk(0, 16'h0046, 3'd0, 3'd0, 3'd2, 2'b01, 2'b01, 4'h4, 1, 0, 1, 0, 0), 0, 0, 16'h0000, 16'd1};
        tbl[7] = '{mk(1, 16'h0048, 3'd0, 3'd0, 3'd2, 2'b01, 2'b01, 4'h4, 1, 0, 0, 0, 1), 0, 0, 16'h0000, 16'd2};
        tbl[8] = '{mk(1, 16'h004A, 3'd0, 3'd0, 3'd2, 2'b10, 2'b10, 4'h0, 1, 1, 0, 0, 0), 0, 1, 16'h004A, 16'd2};
        tbl[9] = '{mk(1, 16'h004C, 3'd0, 3'd2, 3'd7, 2'b10, 2'b01, 4'h5, 1, 0, 0, 0, 1), 1, 0, 16'h0000, 16'd3};
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].in, 1'b1, st);
            chk($sformatf("tbl%0d_stall_ID", i), 128'(st), 128'(tbl[i].e_stall));
            chk($sformatf("tbl%0d_valid_EX", i), 128'(valid_EX), 128'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_PC_EX", i), 128'(PC_EX), 128'(tbl[i].e_pc));
            chk($sformatf("tbl%0d_cnt", i), 128'(bubble_cnt), 128'(tbl[i].e_cnt));
        end
        chk("tbl_op1sel_pc", 128'(Op1_Sel_EX), 128'd0);

        // Flush during a hold is deferred until the hold releases.
        step(mk(1, 16'h0060, 0, 0, 1, 2'b10, 2'b00, 4'h2, 1, 0, 0, 0, 0), 1'b1, st);
        step(mk(1, 16'h0062, 0, 0, 1, 2'b10, 2'b00, 4'h2, 1, 0, 0, 1, 1), 1'b1, st);
        chk("defer_N_pc", 128'(PC_EX), 128'h60);
        step(mk(1, 16'h0064, 0, 0, 1, 2'b10, 2'b00, 4'h2, 1, 0, 0, 1, 0), 1'b1, st);
        chk("defer_N1_pc", 128'(PC_EX), 128'h60);
        chk("defer_N1_cnt", 128'(bubble_cnt), 128'd3);
        step(mk(1, 16'h0066, 0, 0, 1, 2'b10, 2'b00, 4'h2, 1, 0, 0, 0, 0), 1'b1, st);
        chk("defer_N2_valid", 128'(valid_EX), 128'd0);
        chk("defer_N2_cnt", 128'(bubble_cnt), 128'd4);
        step(mk(1, 16'h0068, 0, 0, 1, 2'b10, 2'b00, 4'h2, 1, 0, 0, 0, 0), 1'b1, st);
        chk("defer_N3_pc", 128'(PC_EX), 128'h68);

        // Reset while a flush is pending must discard it.
        step(mk(1, 16'h0070, 0, 0, 1, 2'b10, 2'b00, 4'h2, 1, 0, 0, 1, 1), 1'b1, st);
        step(mk(1, 16'h0072, 0, 0, 1, 2'b10, 2'b00, 4'h2, 1, 0, 0, 1, 0), 1'b0, st);
        step(mk(1, 16'h0074, 0, 0, 1, 2'b10, 2'b00, 4'h2, 1, 0, 0, 0, 0), 1'b1, st);
        chk("rst_pend_pc", 128'(PC_EX), 128'h74);
        chk("rst_pend_cnt", 128'(bubble_cnt), 128'd0);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) step(rnd(), ($urandom_range(0, 49) != 0), st);

        // Saturation: reset, 65534 flushes, then three more.
        step(ZERO, 1'b0, st);
        for (int i = 0; i < 65534; i++)
            step(mk(1, 16'h0100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1, st);
        chk("sat_preload", 128'(bubble_cnt), 128'hFFFE);
        for (int i = 0; i < 3; i++) begin
            step(mk(1, 16'h0100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1, st);
            chk($sformatf("sat_%0d", i), 128'(bubble_cnt), 128'hFFFF);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
